// File: rtl/fifo_rd_stream.sv
// Pop-side stream adapter for the d1spfifo family: credit-based pops, RD_LAT return capture, valid/ready out.
// Optional statistics ports (stall_cnt, hwm) are built when FIFO_RDS_STATS_EN is defined.
module fifo_rd_stream #(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       fifo_empty,
    input  logic                       fifo_valid,
    input  logic [WIDTH-1:0]           fifo_rdata,
    output logic                       fifo_pop,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err_unexp
`ifdef FIFO_RDS_STATS_EN
   ,output logic [CNT_W-1:0]           stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("fifo_rd_stream: RD_LAT must be in 1..4");
        end
        if (DEPTH < RD_LAT) begin : g_bad_depth
            $error("fifo_rd_stream: DEPTH must be >= RD_LAT");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("fifo_rd_stream: CNT_W must be >= 1");
        end
    endgenerate

    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic [RD_LAT-1:0] discard_q, discard_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              m_valid_q, m_valid_d;
    logic [WIDTH-1:0]  m_data_q, m_data_d;
    logic              err_q, err_d;

    logic ret;
    logic hs;
    logic wr_en;
    int   outstanding;
    int   credit;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        outstanding = 0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            outstanding = outstanding + int'(inflight_q[i]);
        end
        hs       = m_valid_q & m_ready;
        credit   = DEPTH - int'(level_q) - outstanding + int'(hs);
        fifo_pop = !fifo_empty && !flush && (credit > 0);
    end

    assign ret   = inflight_q[RD_LAT-1];
    assign wr_en = fifo_valid & ret & !discard_q[RD_LAT-1];

    always_comb begin
        // On flush the discard pipe takes the shifted inflight pipe so it stays aligned with ret.
        inflight_d    = '0;
        discard_d     = '0;
        inflight_d[0] = fifo_pop;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
            discard_d[i]  = flush ? inflight_q[i-1] : discard_q[i-1];
        end

        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (wr_en) begin
            mem_d[wr_idx_q] = fifo_rdata;
            wr_idx_d        = next_idx(wr_idx_q);
        end
        if (hs) begin
            rd_idx_d = next_idx(rd_idx_q);
        end
        level_d = level_q + LVL_W'(wr_en) - LVL_W'(hs);

        // Output register is loaded with the post-update head so m_data never sees fifo_rdata combinationally.
        m_valid_d = (level_d != '0);
        m_data_d  = (level_d != '0) ? mem_d[rd_idx_d] : m_data_q;
        err_d     = err_q | (fifo_valid & !ret);

        if (flush) begin
            wr_idx_d  = '0;
            rd_idx_d  = '0;
            level_d   = '0;
            m_valid_d = 1'b0;
            m_data_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            discard_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            mem_q      <= mem_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            level_q    <= level_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            err_q      <= err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign level     = level_q;
    assign err_unexp = err_q;

`ifdef FIFO_RDS_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [LVL_W-1:0] hwm_q, hwm_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        hwm_d = (level_d > hwm_q) ? level_d : hwm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            hwm_q       <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            hwm_q       <= hwm_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign hwm       = hwm_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: upstream FIFO with RD_LAT read latency plus a word-level reference model.
// Statistics checks are compiled in when FIFO_RDS_STATS_EN is defined.
module tb_fifo_rd_stream;

    localparam int WIDTH  = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 16;
    localparam int LW     = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [LW-1:0]    level;
    logic             err_unexp;
`ifdef FIFO_RDS_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [LW-1:0]    hwm;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH (WIDTH),
        .RD_LAT(RD_LAT),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid),
        .fifo_rdata(fifo_rdata),
        .fifo_pop  (fifo_pop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .err_unexp (err_unexp)
`ifdef FIFO_RDS_STATS_EN
       ,.stall_cnt (stall_cnt),
        .hwm       (hwm)
`endif
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Upstream FIFO contents and its read-return pipe.
    logic [WIDTH-1:0] up_q [$];
    logic             pv [RD_LAT];
    logic [WIDTH-1:0] pd [RD_LAT];
    logic             force_v;

    // Words owed to the consumer, in order, with the cycle they become visible.
    logic [WIDTH-1:0] exp_d [$];
    int               exp_t [$];
    logic [WIDTH-1:0] last_data;
    logic             exp_err;
    int               stall_exp;
    int               hwm_exp;

    int cyc = 0;
    int n_deliv = 0;
    int n_pops = 0;
    int first_pop_cyc, first_val_cyc, first_hs_cyc, last_hs_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int arrived();
        int n = 0;
        foreach (exp_t[i]) if (exp_t[i] <= cyc) n++;
        return n;
    endfunction

    function automatic int pv_cnt();
        int n = 0;
        for (int i = 0; i < RD_LAT; i++) if (pv[i]) n++;
        return n;
    endfunction

    function automatic void drive_up();
        fifo_empty = (up_q.size() == 0);
        fifo_valid = pv[RD_LAT-1] | force_v;
        fifo_rdata = force_v ? 16'hDEAD : pd[RD_LAT-1];
    endfunction

    function automatic void clear_model();
        up_q.delete();
        exp_d.delete();
        exp_t.delete();
        for (int i = 0; i < RD_LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        last_data = '0;
        exp_err   = 1'b0;
        stall_exp = 0;
        hwm_exp   = 0;
    endfunction

    task automatic step();
        int   arr;
        logic hs_m, exp_pop, pop_obs, popped;
        @(negedge clk);
        arr = arrived();
        chk("m_valid", 32'(m_valid), 32'(arr > 0));
        chk("level", 32'(level), 32'(arr));
        chk("err_unexp", 32'(err_unexp), 32'(exp_err));
        if (arr > 0) chk("m_data", 32'(m_data), 32'(exp_d[0]));
        else         chk("m_data_hold", 32'(m_data), 32'(last_data));
        hs_m    = (arr > 0) && m_ready;
        exp_pop = (up_q.size() != 0) && !flush && ((arr + pv_cnt() - int'(hs_m)) < DEPTH);
        chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        pop_obs = fifo_pop;
        if (m_valid && m_ready) begin
            n_deliv++;
            last_hs_cyc = cyc;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
        end
        if (m_valid && first_val_cyc < 0) first_val_cyc = cyc;
`ifdef FIFO_RDS_STATS_EN
        if (arr > hwm_exp) hwm_exp = arr;
        chk("hwm", 32'(hwm), 32'(hwm_exp));
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
        if (arr > 0 && !m_ready && stall_exp < (2**CNT_W - 1)) stall_exp++;
`endif
        @(posedge clk);
        #1;
        popped = pop_obs && (up_q.size() != 0);
        if (hs_m) begin
            last_data = exp_d[0];
            void'(exp_d.pop_front());
            void'(exp_t.pop_front());
        end
        if (force_v && !pv[RD_LAT-1]) exp_err = 1'b1;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = popped;
        pd[0] = '0;
        if (popped) begin
            n_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            pd[0] = up_q[0];
            exp_d.push_back(up_q[0]);
            exp_t.push_back(cyc + RD_LAT + 1);
            void'(up_q.pop_front());
        end
        if (flush) begin
            exp_d.delete();
            exp_t.delete();
            up_q.delete();
            last_data = '0;
        end
        cyc++;
        drive_up();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_err", 32'(err_unexp), 32'(0));
`ifdef FIFO_RDS_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        chk("rst_hwm", 32'(hwm), 32'(0));
`endif
        clear_model();
        m_ready = 1'b0;
        flush   = 1'b0;
        force_v = 1'b0;
        drive_up();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0, d0;
        logic [WIDTH-1:0] held;
        flush   = 1'b0;
        m_ready = 1'b0;
        force_v = 1'b0;
        clear_model();
        drive_up();
        #2;
        do_reset();

        // Stream 0x0001..0x0010 with the consumer always ready.
        first_pop_cyc = -1; first_val_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
        d0 = n_deliv;
        for (int i = 1; i <= 16; i++) up_q.push_back(WIDTH'(i));
        m_ready = 1'b1;
        drive_up();
        for (int i = 0; i < 25; i++) step();
        chk("s1_count", 32'(n_deliv - d0), 32'(16));
        chk("s1_latency", 32'(first_val_cyc - first_pop_cyc), 32'(RD_LAT + 1));
        chk("s1_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 32'(15));

        // Backpressure for 10 cycles mid-stream.
        for (int i = 0; i < 20; i++) up_q.push_back(16'h0100 + WIDTH'(i));
        drive_up();
        for (int i = 0; i < 5; i++) step();
        m_ready = 1'b0;
        held = m_data;
        for (int i = 0; i < 10; i++) step();
        chk("bp_level", 32'(level), 32'(DEPTH));
        chk("bp_nopop", 32'(fifo_pop), 32'(0));
        chk("bp_hold", 32'(m_data), 32'(held));
`ifdef FIFO_RDS_STATS_EN
        chk("bp_stall_cnt", 32'(stall_cnt), 32'(10));
        chk("bp_hwm", 32'(hwm), 32'(DEPTH));
`endif
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();

        // Flush with two pops in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) up_q.push_back(16'h0200 + WIDTH'(i));
        drive_up();
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("flush_level", 32'(level), 32'(0));
        chk("flush_mvalid", 32'(m_valid), 32'(0));
        chk("flush_err", 32'(err_unexp), 32'(0));
        up_q.push_back(16'hA5A5);
        m_ready = 1'b1;
        drive_up();
        for (int i = 0; i < 6; i++) step();
        chk("post_flush_word", 32'(m_data), 32'(16'hA5A5));

        // Single word with a toggling consumer.
        p0 = n_pops;
        d0 = n_deliv;
        up_q.push_back(16'h3C3C);
        drive_up();
        for (int i = 0; i < 12; i++) begin
            m_ready = ~m_ready;
            step();
        end
        chk("s5_pops", 32'(n_pops - p0), 32'(1));
        chk("s5_deliv", 32'(n_deliv - d0), 32'(1));

        // Unexpected return with nothing outstanding.
        m_ready = 1'b1;
        force_v = 1'b1;
        drive_up();
        step();
        force_v = 1'b0;
        drive_up();
        chk("err_set", 32'(err_unexp), 32'(1));
        chk("err_level", 32'(level), 32'(0));
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("err_sticky", 32'(err_unexp), 32'(1));

        do_reset();

        // Randomised traffic with occasional flushes and one mid-stream reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            m_ready = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 59) == 0);
            if (up_q.size() < 8 && $urandom_range(0, 9) < 5) up_q.push_back(WIDTH'($urandom));
            drive_up();
            step();
        end
        flush = 1'b0;

        do_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
